// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: req/ack data-memory port, store lane replication and
// strobes, load formatting, and a pipeline stall until each access completes or is rejected.
module mem_stage_lsu #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        EXMEM_MemRead,
    input  logic        EXMEM_MemWrite,
    input  logic [2:0]  EXMEM_funct3,
    input  logic [31:0] EXMEM_ALU_result,
    input  logic [31:0] EXMEM_rs2_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] Mem_out,
    output logic        mem_stall,
    output logic [1:0]  mem_exc
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_exc;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;

    logic        w_access;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_valid;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_timeout;

    assign w_access     = EXMEM_MemRead | EXMEM_MemWrite;
    assign w_illegal    = (EXMEM_funct3 == 3'b011) || (EXMEM_funct3[2:1] == 2'b11);
    assign w_misaligned = ((EXMEM_funct3[1:0] == 2'b10) && (EXMEM_ALU_result[1:0] != 2'b00)) ||
                          ((EXMEM_funct3[1:0] == 2'b01) && EXMEM_ALU_result[0]);
    assign w_valid      = w_access && !w_illegal && !w_misaligned;
    assign w_timeout    = (r_cnt == 8'(ACK_TIMEOUT - 1));

    always_comb begin
        w_wstrb = 4'b0000;
        w_wdata = EXMEM_rs2_data;
        unique case (EXMEM_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << EXMEM_ALU_result[1:0];
                w_wdata = {4{EXMEM_rs2_data[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << EXMEM_ALU_result[1:0];
                w_wdata = {2{EXMEM_rs2_data[15:0]}};
            end
            default: w_wstrb = 4'b1111;
        endcase
        // A store wins when both MemRead and MemWrite are set; reads never enable lanes
        if (!EXMEM_MemWrite) begin
            w_wstrb = 4'b0000;
        end
    end

    assign w_byte = 8'(dmem_rdata >> {r_lane, 3'b000});
    assign w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        w_load = dmem_rdata;
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = dmem_rdata;
        endcase
    end

    always_comb begin
        mem_exc = 2'b00;
        if (r_state == StIdle && w_access) begin
            if (w_illegal) begin
                mem_exc = 2'b10;
            end else if (w_misaligned) begin
                mem_exc = 2'b01;
            end
        end else if (r_state == StDone) begin
            mem_exc = r_exc;
        end
    end

    assign mem_stall = (r_state == StBusy) || (r_state == StIdle && w_valid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= StIdle;
            r_cnt      <= 8'd0;
            r_exc      <= 2'b00;
            r_funct3   <= 3'b000;
            r_lane     <= 2'b00;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            dmem_wstrb <= 4'b0000;
            Mem_out    <= 32'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_valid) begin
                        r_funct3   <= EXMEM_funct3;
                        r_lane     <= EXMEM_ALU_result[1:0];
                        dmem_req   <= 1'b1;
                        dmem_we    <= EXMEM_MemWrite;
                        dmem_addr  <= {EXMEM_ALU_result[31:2], 2'b00};
                        dmem_wdata <= w_wdata;
                        dmem_wstrb <= w_wstrb;
                        r_cnt      <= 8'd0;
                        r_state    <= StBusy;
                    end
                end
                StBusy: begin
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            Mem_out <= w_load;
                        end
                        dmem_req <= 1'b0;
                        r_state  <= StDone;
                    end else if (w_timeout) begin
                        dmem_req <= 1'b0;
                        Mem_out  <= 32'd0;
                        r_exc    <= 2'b11;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StDone: begin
                    r_cnt   <= 8'd0;
                    r_exc   <= 2'b00;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases followed by randomized accesses checked against
// a byte-level reference model of loads, stores, rejections and timeouts.
module tb_mem_stage_lsu;

    localparam int unsigned TIMEOUT = 4;

    logic        clk;
    logic        rstn;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] rs2_data;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] mem_out;
    logic        mem_stall;
    logic [1:0]  mem_exc;

    int          checks;
    int          failures;
    int          exp_issues;
    int          req_rises;
    logic [31:0] exp_mem_out;

    mem_stage_lsu #(.ACK_TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .EXMEM_MemRead    (mem_read),
        .EXMEM_MemWrite   (mem_write),
        .EXMEM_funct3     (funct3),
        .EXMEM_ALU_result (alu_result),
        .EXMEM_rs2_data   (rs2_data),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_ack         (dmem_ack),
        .dmem_rdata       (dmem_rdata),
        .Mem_out          (mem_out),
        .mem_stall        (mem_stall),
        .mem_exc          (mem_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge dmem_req) req_rises++;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int acc_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] s;
        int lo;
        int n;
        n  = acc_size(f3);
        lo = int'(addr[1:0]);
        s  = 4'b0000;
        for (int i = 0; i < 4; i++) s[i] = (i >= lo) && (i < lo + n);
        return s;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] w;
        int n;
        n = acc_size(f3);
        w = 32'd0;
        for (int i = 0; i < 4; i++) w = w | (((rs2 >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        int n;
        n = acc_size(f3);
        if (n == 4) return rdata;
        v = (rdata >> (8 * int'(addr[1:0]))) & ((32'd1 << (8 * n)) - 32'd1);
        if (!f3[2] && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ack_at: BUSY cycle (0-based) in which ack is returned; >= TIMEOUT means never
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rs2,
                              input int ack_at, input logic [31:0] rdata);
        logic       illegal;
        logic       misal;
        logic [1:0] rej_exc;
        logic       timed_out;
        int         n;
        illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        n       = acc_size(f3);
        misal   = (n == 4 && addr[1:0] != 2'b00) || (n == 2 && addr[0]);
        rej_exc = illegal ? 2'b10 : (misal ? 2'b01 : 2'b00);
        @(negedge clk);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        alu_result = addr;
        rs2_data   = rs2;
        dmem_rdata = $urandom;
        #1;
        if (illegal || misal) begin
            chk("rej_stall", 32'(mem_stall), 32'd0);
            chk("rej_exc", 32'(mem_exc), 32'(rej_exc));
            @(negedge clk);
            chk("rej_req", 32'(dmem_req), 32'd0);
            chk("rej_memout", mem_out, exp_mem_out);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            return;
        end
        chk("idle_stall", 32'(mem_stall), 32'd1);
        chk("idle_exc", 32'(mem_exc), 32'd0);
        exp_issues++;
        timed_out = 1'b1;
        for (int c = 0; c < int'(TIMEOUT); c++) begin
            @(negedge clk);
            chk("busy_req", 32'(dmem_req), 32'd1);
            chk("busy_we", 32'(dmem_we), 32'(wr));
            chk("busy_addr", dmem_addr, {addr[31:2], 2'b00});
            chk("busy_wstrb", 32'(dmem_wstrb), wr ? 32'(model_strb(f3, addr)) : 32'd0);
            if (wr) chk("busy_wdata", dmem_wdata, model_wdata(f3, rs2));
            chk("busy_stall", 32'(mem_stall), 32'd1);
            chk("busy_exc", 32'(mem_exc), 32'd0);
            if (c == ack_at) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
                timed_out  = 1'b0;
                break;
            end
        end
        @(negedge clk);
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        if (timed_out) begin
            exp_mem_out = 32'd0;
        end else if (!wr) begin
            exp_mem_out = model_load(f3, addr, rdata);
        end
        chk("done_req", 32'(dmem_req), 32'd0);
        chk("done_stall", 32'(mem_stall), 32'd0);
        chk("done_exc", 32'(mem_exc), timed_out ? 32'd3 : 32'd0);
        chk("done_memout", mem_out, exp_mem_out);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        logic [2:0] f3;
        logic       rd;
        logic       wr;
        logic [31:0] addr;
        checks      = 0;
        failures    = 0;
        exp_issues  = 0;
        req_rises   = 0;
        exp_mem_out = 32'd0;
        f3_tab      = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rstn        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        funct3      = 3'b010;
        alu_result  = 32'd0;
        rs2_data    = 32'd0;
        dmem_ack    = 1'b0;
        dmem_rdata  = 32'd0;
        #12;
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
        chk("rst_memout", mem_out, 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_exc", 32'(mem_exc), 32'd0);
        rstn = 1'b1;

        run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FF1234);
        run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80FF1234);
        run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF1234);
        run_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80FF1234);
        run_access(1'b0, 1'b1, 3'b000, 32'h201, 32'hA5, 2, 32'h0);
        run_access(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, TIMEOUT, 32'h0);
        @(negedge clk);
        chk("post_to_exc", 32'(mem_exc), 32'd0);
        chk("post_to_stall", 32'(mem_stall), 32'd0);

        run_access(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 0, 32'h11112222);
        run_access(1'b0, 1'b1, 3'b010, 32'h14, 32'hCAFEF00D, 0, 32'h0);
        chk("b2b_issues", 32'(req_rises), 32'(exp_issues));

        // Late ack in IDLE must be ignored
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("late_ack_memout", mem_out, exp_mem_out);
        chk("late_ack_req", 32'(dmem_req), 32'd0);

        // Reset while BUSY abandons the access
        @(negedge clk);
        mem_read   = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h40;
        exp_issues++;
        @(negedge clk);
        chk("mid_busy_req", 32'(dmem_req), 32'd1);
        mem_read = 1'b0;
        rstn     = 1'b0;
        #1;
        exp_mem_out = 32'd0;
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stall), 32'd0);
        chk("mid_rst_memout", mem_out, exp_mem_out);
        @(negedge clk);
        rstn       = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("post_rst_memout", mem_out, exp_mem_out);
        chk("post_rst_req", 32'(dmem_req), 32'd0);

        for (int k = 0; k < 40; k++) begin
            f3   = f3_tab[$urandom_range(0, 7)];
            wr   = 1'($urandom_range(0, 1));
            rd   = wr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (wr && (f3 == 3'b100 || f3 == 3'b101)) f3 = {1'b0, f3[1:0]};
            addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            run_access(rd, wr, f3, addr, $urandom, $urandom_range(0, TIMEOUT), $urandom);
        end
        chk("total_issues", 32'(req_rises), 32'(exp_issues));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
